bcd_convert_ctrl: RTL and testbench

BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

---
 rtl/bcd_convert_ctrl_pkg.sv | 16 +
 rtl/bcd_convert_ctrl_if.sv | 37 +++
 rtl/bcd_convert_ctrl_digit_adj.sv | 9 +
 rtl/bcd_convert_ctrl.sv | 100 ++++++++++
 tb/tb_bcd_convert_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared types and sizing for the binary-to-BCD conversion controller.
// Fixed 8-bit operand, three BCD digits, two round-robin requesters.
package bcd_pkg;
    localparam int BIN_W   = 8;
    localparam int DIGITS  = 3;
    localparam int DIG_W   = 4;
    localparam int SHIFT_W = 20;
    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Requester, result and status bundle for bcd_convert_ctrl.
// master = requesters/consumer side, slave = converter side.
interface bcd_convert_ctrl_if;
    import bcd_pkg::*;

    logic             req0_valid;
    logic [BIN_W-1:0] req0_binary;
    logic             req0_ready;
    logic             req1_valid;
    logic [BIN_W-1:0] req1_binary;
    logic             req1_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_id;
    logic [DIG_W-1:0] hundreds;
    logic [DIG_W-1:0] tens;
    logic [DIG_W-1:0] ones;
    logic             busy;

    modport master (
        output req0_valid, req0_binary,
        output req1_valid, req1_binary,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_id,
        input  hundreds, tens, ones, busy
    );

    modport slave (
        input  req0_valid, req0_binary,
        input  req1_valid, req1_binary,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_id,
        output hundreds, tens, ones, busy
    );
endinterface

// File: rtl/bcd_convert_ctrl_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD field holding 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_convert_ctrl.sv
// Two-requester round-robin front end around a serial double-dabble
// converter; one operand in flight, result held until consumed.
module bcd_convert_ctrl
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    bcd_convert_ctrl_if.slave  bus
);
    state_t             state_q;
    state_t             state_d;
    logic [SHIFT_W-1:0] sr_q;
    logic [SHIFT_W-1:0] sr_adj;
    logic [SHIFT_W-1:0] sr_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic               id_q;
    logic [DIG_W-1:0]   hun_q;
    logic [DIG_W-1:0]   ten_q;
    logic [DIG_W-1:0]   one_q;
    logic               take;
    logic               grant;
    logic [BIN_W-1:0]   operand;
    logic               last_shift;

    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr_q[BIN_W+DIG_W*k +: DIG_W]),
            .dout (sr_adj[BIN_W+DIG_W*k +: DIG_W])
        );
    end

    assign sr_next    = {sr_adj[SHIFT_W-2:0], 1'b0};
    assign operand    = grant ? bus.req1_binary : bus.req0_binary;
    assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rst && (bus.req0_valid || bus.req1_valid)) begin
                    take    = 1'b1;
                    // Contention goes to whoever was not served last.
                    grant   = (bus.req0_valid && bus.req1_valid)
                            ? !last_q : bus.req1_valid;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            hun_q   <= '0;
            ten_q   <= '0;
            one_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                sr_q   <= {{(SHIFT_W-BIN_W){1'b0}}, operand};
                cnt_q  <= '0;
                id_q   <= grant;
                last_q <= grant;
            end else if (state_q == SHIFT) begin
                sr_q  <= sr_next;
                cnt_q <= cnt_q + 1'b1;
                if (last_shift) begin
                    hun_q <= sr_next[19:16];
                    ten_q <= sr_next[15:12];
                    one_q <= sr_next[11:8];
                end
            end
        end
    end

    assign bus.req0_ready = take && !grant;
    assign bus.req1_ready = take && grant;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_id     = id_q;
    assign bus.hundreds   = hun_q;
    assign bus.tens       = ten_q;
    assign bus.ones       = one_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Table, directed and random checks of bcd_convert_ctrl against
// an arithmetic reference (div/mod digits, round-robin grant history).
module tb_bcd_convert_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   last_g;

    bcd_convert_ctrl_if bus ();

    bcd_convert_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v0;
        logic [7:0] b0;
        bit         v1;
        logic [7:0] b1;
        int         stall;
        bit         eid;
        logic [3:0] eh;
        logic [3:0] et;
        logic [3:0] eo;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_grant(input bit v0, input bit v1);
        return (v0 && v1) ? !last_g : v1;
    endfunction

    task automatic drive(input bit v0, input logic [7:0] b0,
                         input bit v1, input logic [7:0] b1);
        bus.req0_valid  = v0;
        bus.req0_binary = b0;
        bus.req1_valid  = v1;
        bus.req1_binary = b1;
    endtask

    // Called in an IDLE cycle with requests already driven.
    task automatic transact(input int stall, input bit eid,
                            input logic [3:0] eh, input logic [3:0] et,
                            input logic [3:0] eo);
        #1;
        chk("ready0_grant", int'(bus.req0_ready), int'(!eid));
        chk("ready1_grant", int'(bus.req1_ready), int'(eid));
        chk("busy_idle", int'(bus.busy), 0);
        tick;
        if (eid) bus.req1_valid = 1'b0;
        else     bus.req0_valid = 1'b0;
        last_g = eid;
        for (int i = 1; i <= 9; i++) begin
            #1;
            chk("out_valid_latency", int'(bus.out_valid), int'(i == 9));
            chk("ready_while_busy",
                int'(bus.req0_ready | bus.req1_ready), 0);
            chk("busy", int'(bus.busy), 1);
            if (i < 9) tick;
        end
        chk("hundreds", int'(bus.hundreds), int'(eh));
        chk("tens", int'(bus.tens), int'(et));
        chk("ones", int'(bus.ones), int'(eo));
        chk("out_id", int'(bus.out_id), int'(eid));
        for (int s = 0; s < stall; s++) begin
            tick;
            #1;
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_digits",
                int'({bus.hundreds, bus.tens, bus.ones}),
                int'({eh, et, eo}));
            chk("hold_id", int'(bus.out_id), int'(eid));
            chk("hold_no_ready",
                int'(bus.req0_ready | bus.req1_ready), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("done_no_ready", int'(bus.req0_ready | bus.req1_ready), 0);
        chk("done_valid", int'(bus.out_valid), 1);
        tick;
        bus.out_ready = 1'b0;
        #1;
        chk("back_idle", int'(bus.busy), 0);
        chk("idle_no_valid", int'(bus.out_valid), 0);
    endtask

    task automatic run_val(input int stall, input bit eid, input int v);
        transact(stall, eid, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
    endtask

    initial begin
        bit         p0;
        bit         p1;
        bit         g;
        logic [7:0] o0;
        logic [7:0] o1;
        int         v;

        tbl[0] = '{1'b1, 8'd255, 1'b0, 8'd0,  0, 1'b0, 4'd2, 4'd5, 4'd5};
        tbl[1] = '{1'b0, 8'd0,   1'b1, 8'd0,  0, 1'b1, 4'd0, 4'd0, 4'd0};
        tbl[2] = '{1'b1, 8'd199, 1'b0, 8'd0,  5, 1'b0, 4'd1, 4'd9, 4'd9};
        tbl[3] = '{1'b0, 8'd0,   1'b1, 8'd9,  2, 1'b1, 4'd0, 4'd0, 4'd9};
        tbl[4] = '{1'b1, 8'd10,  1'b0, 8'd0,  1, 1'b0, 4'd0, 4'd1, 4'd0};
        tbl[5] = '{1'b0, 8'd0,   1'b1, 8'd99, 0, 1'b1, 4'd0, 4'd9, 4'd9};
        tbl[6] = '{1'b1, 8'd128, 1'b0, 8'd0,  3, 1'b0, 4'd1, 4'd2, 4'd8};

        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 8'd0);
        tick;
        tick;
        rst = 1'b0;
        last_g = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
        chk("rst_id", int'(bus.out_id), 0);

        // Contention from reset: req0 first, then req1, then req0.
        drive(1'b1, 8'd100, 1'b1, 8'd42);
        transact(0, 1'b0, 4'd1, 4'd0, 4'd0);
        bus.req0_valid = 1'b1;
        chk("model_rr1", int'(model_grant(1'b1, 1'b1)), 1);
        transact(0, 1'b1, 4'd0, 4'd4, 4'd2);
        bus.req1_valid = 1'b1;
        transact(0, 1'b0, 4'd1, 4'd0, 4'd0);
        bus.req1_valid = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v0, tbl[i].b0, tbl[i].v1, tbl[i].b1);
            transact(tbl[i].stall, tbl[i].eid,
                     tbl[i].eh, tbl[i].et, tbl[i].eo);
        end

        // Abort 137 in its 4th SHIFT cycle.
        drive(1'b1, 8'd137, 1'b0, 8'd0);
        tick;
        bus.req0_valid = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_ready_low", int'(bus.req0_ready | bus.req1_ready), 0);
        tick;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        last_g = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
        chk("abort_id", int'(bus.out_id), 0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_valid", int'(bus.out_valid), 0);
            tick;
        end
        drive(1'b1, 8'd137, 1'b0, 8'd0);
        run_val(0, 1'b0, 137);

        for (int n = 0; n < 256; n++) begin
            if (n % 2 == 0) drive(1'b1, 8'(n), 1'b0, 8'd0);
            else            drive(1'b0, 8'd0, 1'b1, 8'(n));
            run_val(0, 1'(n % 2), n);
        end

        p0 = 1'b0;
        p1 = 1'b0;
        o0 = 8'd0;
        o1 = 8'd0;
        repeat (60) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin
                p0 = 1'b1;
                o0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(1, 0) == 1) begin
                p1 = 1'b1;
                o1 = 8'($urandom);
            end
            if (!p0 && !p1) begin
                p0 = 1'b1;
                o0 = 8'($urandom);
            end
            drive(p0, o0, p1, o1);
            g = model_grant(p0, p1);
            v = g ? int'(o1) : int'(o0);
            run_val(int'($urandom_range(3, 0)), g, v);
            if (g) p1 = 1'b0;
            else   p0 = 1'b0;
        end
        drive(1'b0, 8'd0, 1'b0, 8'd0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
